// File: rtl/tac_frame_packer.sv
// tac_frame_packer: collects ordered demodulator readout frames into a FIFO
// and re-emits each complete frame as a framed little-endian byte stream.
// Frame on the wire: A5 5A SEQ DATA[N words] [CSUM].
// Optional feature macro: TAC_PACKER_CSUM_EN adds a trailing XOR checksum byte.
// tx_valid/tx_ready: a byte transfers on a rising clk edge where both are high;
// while tx_valid && !tx_ready, tx_valid, tx_data and tx_last hold their values.
module tac_frame_packer #(
    parameter int DAC_CHANNELS = 16,
    parameter int ADC_CHANNELS = 16,
    parameter int OUT_BITS     = 32,
    parameter int FIFO_DEPTH   = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [$clog2(DAC_CHANNELS)-1:0] in_dac,
    input  logic [$clog2(ADC_CHANNELS)-1:0] in_adc,
    input  logic                            in_phase,
    input  logic [OUT_BITS-1:0]             in_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_last,
    output logic [7:0]                      frame_seq,
    output logic [15:0]                     seq_err_count,
    output logic [15:0]                     drop_count
);

    localparam int N   = 2 * DAC_CHANNELS * ADC_CHANNELS;
    localparam int IW  = $clog2(N);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int BPW = OUT_BITS / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IN_IDLE, IN_COLLECT, IN_DROP} in_state_t;
`ifdef TAC_PACKER_CSUM_EN
    typedef enum logic [2:0] {OUT_IDLE, OUT_HDR0, OUT_HDR1, OUT_SEQ, OUT_DATA, OUT_CSUM} out_state_t;
`else
    typedef enum logic [2:0] {OUT_IDLE, OUT_HDR0, OUT_HDR1, OUT_SEQ, OUT_DATA} out_state_t;
`endif

    in_state_t         in_state_q, in_state_d;
    out_state_t        out_state_q, out_state_d;
    logic [IW-1:0]     exp_q, exp_d;
    logic [PW-1:0]     wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic [15:0]       seq_err_q, seq_err_d, drop_q, drop_d;
    logic [7:0]        seq_q, seq_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [IW-1:0]     word_q, word_d;
    logic              avail_q, avail_d;
`ifdef TAC_PACKER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic [OUT_BITS-1:0] mem_q [FIFO_DEPTH];

    logic [IW-1:0]     in_idx;
    logic              idx_first, idx_last;
    logic              arb;
    logic [PW-1:0]     arb_base;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [7:0]        cur_byte;
    logic              last_byte, last_word;

    assign in_idx    = IW'(in_phase) + IW'(2) * (IW'(in_dac) + IW'(DAC_CHANNELS) * IW'(in_adc));
    assign idx_first = (in_idx == '0);
    assign idx_last  = (in_idx == IW'(N - 1));

    // Input FSM: order checking, free-space arbitration, FIFO write and commit/rollback
    always_comb begin
        in_state_d = in_state_q;
        exp_d      = exp_q;
        wr_d       = wr_q;
        commit_d   = commit_q;
        seq_err_d  = seq_err_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_q[AW-1:0];
        arb        = 1'b0;
        arb_base   = wr_q;
        if (in_valid) begin
            case (in_state_q)
                IN_IDLE: begin
                    if (idx_first) arb = 1'b1;
                end
                IN_COLLECT: begin
                    if (in_idx == exp_q) begin
                        mem_we = 1'b1;
                        wr_d   = wr_q + PW'(1);
                        if (idx_last) begin
                            commit_d   = wr_q + PW'(1);
                            in_state_d = IN_IDLE;
                        end else begin
                            exp_d = exp_q + IW'(1);
                        end
                    end else begin
                        // Out of order: throw away the partial frame
                        wr_d      = commit_q;
                        arb_base  = commit_q;
                        seq_err_d = (seq_err_q == 16'hFFFF) ? seq_err_q : seq_err_q + 16'd1;
                        if (idx_first) arb = 1'b1;
                        else           in_state_d = IN_IDLE;
                    end
                end
                IN_DROP: begin
                    if (idx_first)     arb = 1'b1;
                    else if (idx_last) in_state_d = IN_IDLE;
                end
                default: in_state_d = IN_IDLE;
            endcase
        end
        // A new frame start: accept only if a whole frame is guaranteed to fit
        if (arb) begin
            if ((PW'(FIFO_DEPTH) - (arb_base - rd_q)) >= PW'(N)) begin
                mem_we     = 1'b1;
                mem_waddr  = arb_base[AW-1:0];
                wr_d       = arb_base + PW'(1);
                exp_d      = IW'(1);
                in_state_d = IN_COLLECT;
            end else begin
                drop_d     = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                in_state_d = IN_DROP;
            end
        end
    end

    // Frame buffer storage (no reset: contents are qualified by the pointers)
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= in_data;
    end

    assign cur_byte  = 8'(mem_q[rd_q[AW-1:0]] >> {byte_q, 3'b000});
    assign last_byte = (byte_q == BW'(BPW - 1));
    assign last_word = (word_q == IW'(N - 1));
    // Uses the registered commit pointer so a commit reaches the output FSM a cycle later
    assign avail_d   = (commit_q - rd_d) >= PW'(N);

    // Output FSM: header, sequence, data bytes and optional checksum
    always_comb begin
        out_state_d = out_state_q;
        rd_d        = rd_q;
        byte_d      = byte_q;
        word_d      = word_q;
        seq_d       = seq_q;
`ifdef TAC_PACKER_CSUM_EN
        csum_d      = csum_q;
`endif
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tx_last     = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (avail_q) out_state_d = OUT_HDR0;
            end
            OUT_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) out_state_d = OUT_HDR1;
            end
            OUT_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = 8'h5A;
                if (tx_ready) out_state_d = OUT_SEQ;
            end
            OUT_SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_q;
                if (tx_ready) begin
                    out_state_d = OUT_DATA;
                    byte_d      = '0;
                    word_d      = '0;
`ifdef TAC_PACKER_CSUM_EN
                    csum_d      = seq_q;
`endif
                end
            end
            OUT_DATA: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
`ifndef TAC_PACKER_CSUM_EN
                tx_last  = last_byte && last_word;
`endif
                if (tx_ready) begin
`ifdef TAC_PACKER_CSUM_EN
                    csum_d = csum_q ^ cur_byte;
`endif
                    if (last_byte) begin
                        byte_d = '0;
                        rd_d   = rd_q + PW'(1);
                        if (last_word) begin
`ifdef TAC_PACKER_CSUM_EN
                            out_state_d = OUT_CSUM;
`else
                            out_state_d = OUT_IDLE;
                            seq_d       = seq_q + 8'd1;
`endif
                        end else begin
                            word_d = word_q + IW'(1);
                        end
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
`ifdef TAC_PACKER_CSUM_EN
            OUT_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    out_state_d = OUT_IDLE;
                    seq_d       = seq_q + 8'd1;
                end
            end
`endif
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // State and pointer registers; reset discards all buffered and partial data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            exp_q       <= '0;
            wr_q        <= '0;
            commit_q    <= '0;
            rd_q        <= '0;
            seq_err_q   <= '0;
            drop_q      <= '0;
            seq_q       <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            avail_q     <= 1'b0;
`ifdef TAC_PACKER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            exp_q       <= exp_d;
            wr_q        <= wr_d;
            commit_q    <= commit_d;
            rd_q        <= rd_d;
            seq_err_q   <= seq_err_d;
            drop_q      <= drop_d;
            seq_q       <= seq_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            avail_q     <= avail_d;
`ifdef TAC_PACKER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign frame_seq     = seq_q;
    assign seq_err_count = seq_err_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_tac_frame_packer.sv
// Bench for tac_frame_packer with DAC=2, ADC=2, OUT_BITS=32, FIFO_DEPTH=16 (N=8).
// Expected bytes follow TAC_PACKER_CSUM_EN the same way the design build does.
module tb_tac_frame_packer;

    localparam int N = 8;
`ifdef TAC_PACKER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_dac;
    logic        in_adc;
    logic        in_phase;
    logic [31:0] in_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [7:0]  frame_seq;
    logic [15:0] seq_err_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  exp_seq;
    logic [31:0] frame_d [N];

    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic        prev_last  = 1'b0;

    tac_frame_packer #(
        .DAC_CHANNELS(2),
        .ADC_CHANNELS(2),
        .OUT_BITS(32),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_dac(in_dac),
        .in_adc(in_adc),
        .in_phase(in_phase),
        .in_data(in_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .frame_seq(frame_seq),
        .seq_err_count(seq_err_count),
        .drop_count(drop_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one input word for one clock edge; idx bits map to phase/dac/adc
    task automatic send_word(input int idx, input logic [31:0] d);
        in_valid = 1'b1;
        in_phase = idx[0];
        in_dac   = idx[1];
        in_adc   = idx[2];
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int count);
        for (int i = 0; i < count; i++) send_word(i, frame_d[i]);
    endtask

    task automatic fill_idx();
        for (int i = 0; i < N; i++) frame_d[i] = 32'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) frame_d[i] = $urandom_range(32'hFFFF_FFFF, 0);
    endtask

    // Scoreboard model: bytes the frame in frame_d must produce on the link
    task automatic push_frame();
        logic [7:0] csum;
        logic [7:0] b;
        logic [31:0] w;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, exp_seq});
        csum = exp_seq;
        for (int wi = 0; wi < N; wi++) begin
            w = frame_d[wi];
            for (int bi = 0; bi < 4; bi++) begin
                b = w[8*bi +: 8];
                csum ^= b;
                exp_q.push_back({(!CSUM_ON && wi == N - 1 && bi == 3), b});
            end
        end
        if (CSUM_ON) exp_q.push_back({1'b1, csum});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            step();
            k++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (4) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        exp_q.delete();
        exp_seq = 8'h00;
        rst = 1'b0;
        step();
    endtask

    // Monitor: compares accepted bytes against the scoreboard and checks hold-while-stalled
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
                check("hold_last", 32'(tx_last), 32'(prev_last));
            end
            if (tx_valid && tx_ready) begin
                check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
                end
            end
            stall_prev = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_dac   = 1'b0;
        in_adc   = 1'b0;
        in_phase = 1'b0;
        in_data  = 32'd0;
        tx_ready = 1'b0;
        exp_seq  = 8'h00;
        repeat (2) step();

        // Reset values
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_last", 32'(tx_last), 32'd0);
        check("rst_frame_seq", 32'(frame_seq), 32'd0);
        check("rst_seq_err", 32'(seq_err_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;
        step();

        // Ordered frame, data = idx, with commit-to-valid latency
        tx_ready = 1'b1;
        fill_idx();
        push_frame();
        send_frame(N);
        check("lat_edge0", 32'(tx_valid), 32'd0);
        step();
        check("lat_edge1", 32'(tx_valid), 32'd0);
        step();
        check("lat_edge2", 32'(tx_valid), 32'd1);
        wait_drain(100);
        check("ordered_frame_seq", 32'(frame_seq), 32'd1);

        // Order error: idx 0,1,2,5 then a clean frame
        do_reset();
        send_word(0, 32'h11);
        send_word(1, 32'h22);
        send_word(2, 32'h33);
        send_word(5, 32'h44);
        check("order_seq_err", 32'(seq_err_count), 32'd1);
        repeat (5) step();
        check("order_no_tx", 32'(tx_valid), 32'd0);
        fill_rand();
        push_frame();
        send_frame(N);
        wait_drain(100);
        check("order_frame_seq", 32'(frame_seq), 32'd1);
        check("order_drop", 32'(drop_count), 32'd0);

        // Overflow: three frames with the sink stalled, only two fit
        do_reset();
        tx_ready = 1'b0;
        fill_rand();
        push_frame();
        send_frame(N);
        fill_rand();
        push_frame();
        send_frame(N);
        fill_rand();
        send_frame(N);
        check("ovf_drop", 32'(drop_count), 32'd1);
        check("ovf_seq_err", 32'(seq_err_count), 32'd0);
        check("ovf_stalled_hdr", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        wait_drain(200);
        check("ovf_frame_seq", 32'(frame_seq), 32'd2);

        // Backpressure: tx_ready toggles every cycle
        do_reset();
        tx_ready = 1'b0;
        fill_idx();
        push_frame();
        send_frame(N);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            tx_ready = ~tx_ready;
            step();
        end
        tx_ready = 1'b1;
        wait_drain(20);
        check("bp_frame_seq", 32'(frame_seq), 32'd1);

        // Reset mid-frame during transmission
        do_reset();
        tx_ready = 1'b1;
        fill_rand();
        push_frame();
        send_frame(N);
        wait_drain(100);
        check("pre_rst_frame_seq", 32'(frame_seq), 32'd1);
        fill_rand();
        push_frame();
        send_frame(N);
        send_frame(4);
        check("pre_rst_tx_active", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_tx_last", 32'(tx_last), 32'd0);
        check("midrst_frame_seq", 32'(frame_seq), 32'd0);
        check("midrst_seq_err", 32'(seq_err_count), 32'd0);
        check("midrst_drop", 32'(drop_count), 32'd0);
        exp_q.delete();
        exp_seq = 8'h00;
        step();
        rst = 1'b0;
        repeat (6) step();
        check("post_rst_idle", 32'(tx_valid), 32'd0);
        fill_rand();
        push_frame();
        send_frame(N);
        wait_drain(100);
        check("post_rst_frame_seq", 32'(frame_seq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tac_frame_packer.md
# tac_frame_packer

Receive-side companion of the tactile demodulator. Consumes the demodulator's per-frame readout stream of DAC×ADC×2 accumulator words and checks the stream order. Buffers complete frames in a FIFO and re-emits them as a framed byte stream with valid/ready handshake for the host link. Partial, out-of-order or non-fitting frames are discarded whole and counted.

## Interface
- `DAC_CHANNELS`, 16, drive channels per frame
- `ADC_CHANNELS`, 16, sense channels per frame
- `OUT_BITS`, 32, input word width; multiple of 8
- `FIFO_DEPTH`, 1024, buffer words; power of two, ≥ N where N = 2·DAC_CHANNELS·ADC_CHANNELS
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: input word strobe; no backpressure
- `in_dac` in $clog2(DAC_CHANNELS): drive index
- `in_adc` in $clog2(ADC_CHANNELS): sense index
- `in_phase` in 1: 0 = in-phase, 1 = quadrature
- `in_data` in OUT_BITS: accumulator value
- `tx_valid` out 1: byte available
- `tx_ready` in 1: sink accepts byte
- `tx_data` out 8: byte
- `tx_last` out 1: final byte of a frame
- `frame_seq` out 8: frames fully transmitted, mod 256
- `seq_err_count` out 16: aborted frames, saturating
- `drop_count` out 16: frames dropped for lack of space, saturating

## Operation
- Word index is idx = in_phase + 2·(in_dac + DAC_CHANNELS·in_adc). A valid frame is N consecutive in_valid words with idx 0..N-1. Gaps between words are allowed.
- Input FSM has three states:
  - IDLE: on in_valid with idx 0, go to COLLECT if free words ≥ N. Otherwise go to DROP and increment drop_count. Words with idx ≠ 0 are ignored.
  - COLLECT: on in_valid with idx = expected, write the word at wr_ptr and advance. The word idx N-1 commits the frame: commit_ptr ← wr_ptr+1 and the state returns to IDLE. On idx ≠ expected, roll wr_ptr back to commit_ptr and increment seq_err_count. If that word's idx is 0, it re-arbitrates as in IDLE in the same cycle; otherwise go to IDLE.
  - DROP: discard words until the word with idx N-1, then go to IDLE. An idx-0 word during DROP re-arbitrates as in IDLE.
- Free words = FIFO_DEPTH − (wr_ptr − rd_ptr). Pointers use an extra wrap bit and wrap modulo 2·FIFO_DEPTH.
- Output FSM:
  - IDLE → HDR0 when committed words (commit_ptr − rd_ptr) ≥ N.
  - HDR0 sends 0xA5, HDR1 sends 0x5A, SEQ sends frame_seq.
  - DATA sends N words, each as OUT_BITS/8 bytes, little-endian.
  - CSUM, then IDLE.
- State advances only on tx_valid && tx_ready. rd_ptr advances after the last byte of each word.
- frame_seq increments by 1 on acceptance of the frame's last byte and wraps 255→0.
- tx_data, tx_valid and tx_last are stable while tx_valid && !tx_ready.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0, tx_last=0, frame_seq=0, seq_err_count=0, drop_count=0.
  - All pointers 0; both FSMs in IDLE.
- Asserting rst mid-frame discards all buffered and partial data. Outputs take reset values immediately.
- Input is sampled on the rising edge; the write occurs on the same edge.
- Commit is visible to the output FSM on the next cycle. With the output idle, tx_valid rises 2 cycles after the edge that samples word N-1.
- With tx_ready held high, one byte is sent per cycle and there are no bubbles within a frame. Back-to-back committed frames have a 1-cycle IDLE gap.
- Simultaneous commit and read in the same cycle is legal. The free-space test uses the pre-edge rd_ptr, so it is conservative.

## Configuration
- `TAC_PACKER_CSUM_EN` defined: CSUM state is present. tx_data there = XOR of the SEQ byte and all DATA bytes, and tx_last asserts on the CSUM byte.
- `TAC_PACKER_CSUM_EN` undefined: CSUM state is removed, and tx_last asserts on the final DATA byte.

## Test plan
Bench parameters: DAC=2, ADC=2, OUT_BITS=32, FIFO_DEPTH=16, so N=8. CSUM enabled unless noted.
- **Ordered frame:** words idx 0..7 with data = idx, tx_ready=1 → exactly 3+32+1 bytes: A5 5A 00 00 00 00 00 01 00 00 00 … 07 00 00 00 CSUM. CSUM=0x00. tx_last on byte 36; then frame_seq=1.
- **Order error:** idx 0,1,2,5 → seq_err_count=1, no tx activity. A following clean frame is output with SEQ byte 0x00.
- **Overflow:** tx_ready=0; send 3 clean frames → first 2 are buffered and drop_count=1. Then tx_ready=1 → 2 frames are output, with frame_seq ending at 2.
- **Backpressure:** toggle tx_ready every cycle during a frame → byte sequence identical to the first test, each byte held stable while stalled.
- **Reset mid-frame:** assert rst after 4 input words and during tx → all outputs are at reset values. The next clean frame is output with SEQ byte 0x00.
- **Checksum disabled:** `TAC_PACKER_CSUM_EN` undefined, same stimulus as the first test → 35 bytes, tx_last on the 0x00 MSB byte of word 7.
